// File: rtl/tl_ul_link_checker.sv
// tl_ul_link_checker: passive TileLink-UL A/D link checker with sticky error flags and first-error record
// Ports: i_clock/i_reset_n (sync, active-low); A channel i_a_valid/ready/opcode/size/source/address;
// D channel i_d_valid/ready/opcode/size/source; o_err_flags sticky per-class bits, o_err_pulse one cycle
// after an erroring cycle, o_first_code/o_first_src first-error record, o_err_count saturating count.
module tl_ul_link_checker #(
  parameter int SRC_W    = 4,
  parameter int ADDR_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int BEAT_B   = 8,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 16,
  parameter int FATAL_EN = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_a_valid,
  input  logic              i_a_ready,
  input  logic [2:0]        i_a_opcode,
  input  logic [SIZE_W-1:0] i_a_size,
  input  logic [SRC_W-1:0]  i_a_source,
  input  logic [ADDR_W-1:0] i_a_address,
  input  logic              i_d_valid,
  input  logic              i_d_ready,
  input  logic [2:0]        i_d_opcode,
  input  logic [SIZE_W-1:0] i_d_size,
  input  logic [SRC_W-1:0]  i_d_source,
  output logic [8:0]        o_err_flags,
  output logic              o_err_pulse,
  output logic [3:0]        o_first_code,
  output logic [SRC_W-1:0]  o_first_src,
  output logic [CNT_W-1:0]  o_err_count
);
  localparam int NS = 1 << SRC_W;
  localparam int LB = $clog2(BEAT_B);
  localparam int BW = 1 << SIZE_W;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

  function automatic logic [BW-1:0] beats(input logic [SIZE_W-1:0] s);
    return (int'(s) > LB) ? BW'(1) << (int'(s) - LB) : BW'(1);
  endfunction

  logic [NS-1:0]             r_busy, r_is_get;
  logic [NS-1:0][SIZE_W-1:0] r_sz;
  logic                      r_a_hold, r_d_hold;
  logic [2:0]                r_a_op, r_d_op, r_ab_op, r_db_op;
  logic [SIZE_W-1:0]         r_a_sz, r_d_sz, r_ab_sz, r_db_sz;
  logic [SRC_W-1:0]          r_a_src, r_d_src, r_ab_src, r_db_src;
  logic [ADDR_W-1:0]         r_a_addr;
  logic [BW-1:0]             r_a_cnt, r_d_cnt;
  logic [TW-1:0]             r_wd;
  logic [8:0]                r_flags;
  logic                      r_pulse;
  logic [3:0]                r_code;
  logic [SRC_W-1:0]          r_fsrc;
  logic [CNT_W-1:0]          r_cnt;

  logic          w_a_fire, w_d_fire, w_a_first, w_d_first, w_a_put, w_d_last, w_d_idle;
  logic          w_d_retire, w_a_busy;
  logic [BW-1:0] w_a_beats, w_d_beats;
  logic [8:0]    w_err;
  logic [3:0]    w_code;
  logic [SRC_W-1:0] w_fsrc;

  assign w_a_fire  = i_a_valid & i_a_ready;
  assign w_d_fire  = i_d_valid & i_d_ready;
  assign w_a_first = r_a_cnt == '0;
  assign w_d_first = r_d_cnt == '0;
  assign w_a_put   = i_a_opcode == 3'd0 || i_a_opcode == 3'd1;
  assign w_a_beats = beats(i_a_size);
  assign w_d_beats = beats(i_d_size);
  assign w_d_idle  = !r_busy[i_d_source];
  // Only AccessAckData bursts span several beats; AccessAck is always single-beat.
  assign w_d_last  = w_d_first ? (i_d_opcode != 3'd1 || w_d_beats == BW'(1)) : r_d_cnt == BW'(1);
  assign w_d_retire = w_d_fire && w_d_last && !w_d_idle;
  // A response retiring the same source this cycle frees the slot for the new request.
  assign w_a_busy  = r_busy[i_a_source] && !(w_d_retire && i_d_source == i_a_source);

  assign w_err[0] = (r_a_hold && (!i_a_valid || i_a_opcode != r_a_op || i_a_size != r_a_sz ||
                     i_a_source != r_a_src || i_a_address != r_a_addr)) ||
                    (w_a_fire && !w_a_first && (i_a_opcode != r_ab_op || i_a_size != r_ab_sz ||
                     i_a_source != r_ab_src));
  assign w_err[1] = (r_d_hold && (!i_d_valid || i_d_opcode != r_d_op || i_d_size != r_d_sz ||
                     i_d_source != r_d_src)) ||
                    (w_d_fire && !w_d_first && (i_d_opcode != r_db_op || i_d_size != r_db_sz ||
                     i_d_source != r_db_src));
  assign w_err[2] = w_a_fire && !(w_a_put || i_a_opcode == 3'd4);
  assign w_err[3] = w_a_fire && |(i_a_address & ((ADDR_W'(1) << i_a_size) - ADDR_W'(1)));
  assign w_err[4] = w_a_fire && w_a_first && w_a_busy;
  assign w_err[5] = w_d_fire && w_d_first && w_d_idle;
  assign w_err[6] = w_d_fire && w_d_first && !w_d_idle &&
                    (r_is_get[i_d_source] ? i_d_opcode != 3'd1 : i_d_opcode != 3'd0);
  assign w_err[7] = w_d_fire && w_d_first && !w_d_idle && i_d_size != r_sz[i_d_source];
  assign w_err[8] = TIMEOUT != 0 && |r_busy && !w_d_fire && r_wd == TW'(TIMEOUT - 1);

  always_comb begin
    w_code = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (w_err[i]) w_code = 4'(i);
    w_fsrc = w_code == 4'd8 ? '0 :
             (w_code == 4'd1 || (w_code >= 4'd5 && w_code <= 4'd7)) ? i_d_source : i_a_source;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_busy <= '0;
      r_is_get <= '0;
      r_sz <= '0;
      r_a_hold <= 1'b0;
      r_d_hold <= 1'b0;
      r_a_op <= '0;
      r_a_sz <= '0;
      r_a_src <= '0;
      r_a_addr <= '0;
      r_d_op <= '0;
      r_d_sz <= '0;
      r_d_src <= '0;
      r_ab_op <= '0;
      r_ab_sz <= '0;
      r_ab_src <= '0;
      r_db_op <= '0;
      r_db_sz <= '0;
      r_db_src <= '0;
      r_a_cnt <= '0;
      r_d_cnt <= '0;
      r_wd <= '0;
      r_flags <= '0;
      r_pulse <= 1'b0;
      r_code <= '0;
      r_fsrc <= '0;
      r_cnt <= '0;
    end else begin
      r_a_hold <= i_a_valid & ~i_a_ready;
      r_d_hold <= i_d_valid & ~i_d_ready;
      r_a_op <= i_a_opcode;
      r_a_sz <= i_a_size;
      r_a_src <= i_a_source;
      r_a_addr <= i_a_address;
      r_d_op <= i_d_opcode;
      r_d_sz <= i_d_size;
      r_d_src <= i_d_source;
      if (w_a_fire && w_a_first) begin
        r_ab_op <= i_a_opcode;
        r_ab_sz <= i_a_size;
        r_ab_src <= i_a_source;
        r_a_cnt <= w_a_put ? w_a_beats - BW'(1) : '0;
      end else if (w_a_fire)
        r_a_cnt <= r_a_cnt - BW'(1);
      if (w_d_fire && w_d_first) begin
        r_db_op <= i_d_opcode;
        r_db_sz <= i_d_size;
        r_db_src <= i_d_source;
        r_d_cnt <= i_d_opcode == 3'd1 ? w_d_beats - BW'(1) : '0;
      end else if (w_d_fire)
        r_d_cnt <= r_d_cnt - BW'(1);
      if (w_d_retire) r_busy[i_d_source] <= 1'b0;
      if (w_a_fire && w_a_first && !w_a_busy) begin
        r_busy[i_a_source] <= 1'b1;
        r_is_get[i_a_source] <= i_a_opcode == 3'd4;
        r_sz[i_a_source] <= i_a_size;
      end
      if (!(|r_busy) || w_d_fire) r_wd <= '0;
      else if (r_wd != TW'(TIMEOUT)) r_wd <= r_wd + TW'(1);
      r_flags <= r_flags | w_err;
      r_pulse <= |w_err;
      if (r_flags == '0 && |w_err) begin
        r_code <= w_code;
        r_fsrc <= w_fsrc;
      end
      if (|w_err && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clock)
    if (FATAL_EN != 0 && i_reset_n && |w_err)
      $fatal(1, "tl_ul_link_checker: protocol error, classes %b", w_err);
`endif

  assign o_err_flags  = r_flags;
  assign o_err_pulse  = r_pulse;
  assign o_first_code = r_code;
  assign o_first_src  = r_fsrc;
  assign o_err_count  = r_cnt;
endmodule
